door_lock_ctrl: RTL and testbench
=================================

// Module: door_lock_ctrl
// PURPOSE
//  Downstream actuator stage for the door-open decision logic: consumes its 1-bit open
//  decision, drives the lock solenoid for a timed unlock window and supervises the door
//  sensor. Raises an alarm on a forced entry or a door held open too long, and counts
//  granted entries.
// PARAMETERS
//  UNLOCK_CYC  4   cycles unlock is held while the door stays closed (>=1)
//  AJAR_CYC    6   cycles the door may stay open before alarm (>=1)
//  CNT_W       8   timer width; must hold max(UNLOCK_CYC,AJAR_CYC)-1
// PORTS
//  clk          in   1  system clock, rising edge
//  rst_n        in   1  synchronous reset, active low
//  open_req     in   1  open decision from the door-open logic, level, 1=grant
//  door_closed  in   1  door sensor, 1=closed
//  alarm_clr    in   1  guard acknowledge, level
//  unlock       out  1  solenoid drive, 1=released
//  alarm        out  1  alarm output
//  state        out  2  0=LOCKED 1=UNLOCKED 2=OPEN 3=ALARM
//  entry_cnt    out  8  granted-entry counter
// BEHAVIOUR
//  - Reset: synchronous, active low, on a clk edge with rst_n=0.
//    Sets state=LOCKED, timer=0, entry_cnt=0, unlock=0, alarm=0.
//    Reset wins in every state, including ALARM and mid-window.
//  - Outputs decode the registered state only.
//    unlock=1 in UNLOCKED and OPEN; alarm=1 in ALARM only.
//    Latency: input sampled at edge N -> output change visible after edge N.
//  - LOCKED:
//    door_closed=0 -> ALARM (forced entry). This takes priority over open_req.
//    Else open_req=1 -> UNLOCKED, timer<=UNLOCK_CYC-1, entry_cnt<=entry_cnt+1.
//  - UNLOCKED, priorities high to low:
//    door_closed=0 -> OPEN, timer<=AJAR_CYC-1.
//    open_req=1 -> stay UNLOCKED, timer reloads UNLOCK_CYC-1 (window extends, no count).
//    timer==0 -> LOCKED.
//    Else timer decrements.
//    With no re-request, unlock stays high for exactly UNLOCK_CYC cycles.
//  - OPEN, priorities high to low:
//    door_closed=1 -> LOCKED.
//    timer==0 -> ALARM.
//    Else timer decrements.
//    open_req is ignored.
//  - ALARM: alarm_clr=1 AND door_closed=1 -> LOCKED. Otherwise hold ALARM.
//    open_req is ignored. alarm_clr while the door is open has no effect.
//  - entry_cnt: unsigned, wraps 255->0 with no flag.
//    Increments only on the LOCKED->UNLOCKED transition.
//  - The timer saturates at 0 and never underflows. Timer value is don't-care in LOCKED/ALARM.
//  - All inputs are synchronous to clk; the block does no synchronisation.
// TESTING (bench uses UNLOCK_CYC=4, AJAR_CYC=6)
//  1. rst_n=0 for 2 edges, then 1 -> state=0, unlock=0, alarm=0, entry_cnt=0.
//  2. open_req pulse 1 cycle, door stays closed -> unlock=1 for exactly 4 cycles,
//     then state=0; entry_cnt=1.
//  3. Grant, door_closed=0 on cycle 2 of the window, closed again after 3 cycles
//     -> state 1->2->0, alarm stays 0.
//  4. Grant, door held open 7 cycles -> state=3 and alarm=1 after the 6th open cycle.
//     alarm_clr with door open -> stays 3. Door closed + alarm_clr -> state=0.
//  5. LOCKED, door_closed=0 and open_req=1 on the same edge -> state=3, entry_cnt unchanged.
//  6. 256 grants -> entry_cnt wraps to 0.
//     rst_n=0 while in OPEN -> state=0, unlock=0 after that edge.

Source files
------------

// File: rtl/door_lock_ctrl.sv
// door_lock_ctrl: lock solenoid sequencer with forced-entry / door-ajar alarm.
// In:  clk, rst_n (sync, active low), open_req, door_closed, alarm_clr.
// Out: unlock, alarm, state[1:0], entry_cnt[7:0].
module door_lock_ctrl #(
    parameter int UNLOCK_CYC = 4,
    parameter int AJAR_CYC   = 6,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       open_req,
    input  logic       door_closed,
    input  logic       alarm_clr,
    output logic       unlock,
    output logic       alarm,
    output logic [1:0] state,
    output logic [7:0] entry_cnt
);

    typedef enum logic [1:0] {
        S_LOCKED   = 2'd0,
        S_UNLOCKED = 2'd1,
        S_OPEN     = 2'd2,
        S_ALARM    = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] UNLOCK_LD = CNT_W'(UNLOCK_CYC - 1);
    localparam logic [CNT_W-1:0] AJAR_LD   = CNT_W'(AJAR_CYC - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [7:0]       cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_LOCKED;
            timer_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_LOCKED: begin
                // Door open while locked is a break-in, even if a grant arrives.
                if (!door_closed) begin
                    state_d = S_ALARM;
                end else if (open_req) begin
                    state_d = S_UNLOCKED;
                    timer_d = UNLOCK_LD;
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            S_UNLOCKED: begin
                if (!door_closed) begin
                    state_d = S_OPEN;
                    timer_d = AJAR_LD;
                end else if (open_req) begin
                    timer_d = UNLOCK_LD;
                end else if (timer_q == '0) begin
                    state_d = S_LOCKED;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_OPEN: begin
                if (door_closed) begin
                    state_d = S_LOCKED;
                end else if (timer_q == '0) begin
                    state_d = S_ALARM;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_ALARM: begin
                // Acknowledge only counts once the door is shut again.
                if (alarm_clr && door_closed) begin
                    state_d = S_LOCKED;
                end
            end
            default: begin
                state_d = S_LOCKED;
            end
        endcase
    end

    assign unlock    = (state_q == S_UNLOCKED) || (state_q == S_OPEN);
    assign alarm     = (state_q == S_ALARM);
    assign state     = state_q;
    assign entry_cnt = cnt_q;

endmodule

// File: tb/tb_door_lock_ctrl.sv
// tb_door_lock_ctrl: directed checks of door_lock_ctrl.
// Uses UNLOCK_CYC=4, AJAR_CYC=6.
module tb_door_lock_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       open_req;
    logic       door_closed;
    logic       alarm_clr;
    logic       unlock;
    logic       alarm;
    logic [1:0] state;
    logic [7:0] entry_cnt;

    int checks = 0;
    int errors = 0;

    door_lock_ctrl #(
        .UNLOCK_CYC(4),
        .AJAR_CYC  (6),
        .CNT_W     (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .open_req   (open_req),
        .door_closed(door_closed),
        .alarm_clr  (alarm_clr),
        .unlock     (unlock),
        .alarm      (alarm),
        .state      (state),
        .entry_cnt  (entry_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        open_req    = 1'b0;
        door_closed = 1'b1;
        alarm_clr   = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        checks++;
        if (state !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d expected 0", state);
        end
        checks++;
        if (unlock !== 1'b0 || alarm !== 1'b0) begin
            errors++;
            $display("FAIL reset_outs: got unlock=%b alarm=%b expected 0 0",
                     unlock, alarm);
        end
        checks++;
        if (entry_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d expected 0", entry_cnt);
        end
    endtask

    task automatic test_unlock_window();
        open_req = 1'b1;
        step();
        open_req = 1'b0;
        checks++;
        if (state !== 2'd1 || entry_cnt !== 8'd1) begin
            errors++;
            $display("FAIL grant: got state=%0d cnt=%0d expected 1 1",
                     state, entry_cnt);
        end
        for (int i = 1; i < 4; i++) begin
            step();
            checks++;
            if (unlock !== 1'b1) begin
                errors++;
                $display("FAIL window_%0d: got unlock=%b expected 1", i, unlock);
            end
        end
        step();
        checks++;
        if (unlock !== 1'b0 || state !== 2'd0) begin
            errors++;
            $display("FAIL window_end: got unlock=%b state=%0d expected 0 0",
                     unlock, state);
        end
    endtask

    task automatic test_open_close();
        open_req = 1'b1;
        step();
        open_req = 1'b0;
        step();
        checks++;
        if (state !== 2'd1) begin
            errors++;
            $display("FAIL oc_unlocked: got %0d expected 1", state);
        end
        door_closed = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (state !== 2'd2 || unlock !== 1'b1) begin
                errors++;
                $display("FAIL oc_open_%0d: got state=%0d unlock=%b expected 2 1",
                         i, state, unlock);
            end
        end
        door_closed = 1'b1;
        step();
        checks++;
        if (state !== 2'd0 || alarm !== 1'b0 || entry_cnt !== 8'd2) begin
            errors++;
            $display("FAIL oc_close: got state=%0d alarm=%b cnt=%0d expected 0 0 2",
                     state, alarm, entry_cnt);
        end
    endtask

    task automatic test_ajar_alarm();
        open_req = 1'b1;
        step();
        open_req    = 1'b0;
        door_closed = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            step();
            checks++;
            if (state !== 2'd2 || alarm !== 1'b0) begin
                errors++;
                $display("FAIL ajar_%0d: got state=%0d alarm=%b expected 2 0",
                         i, state, alarm);
            end
        end
        step();
        checks++;
        if (state !== 2'd3 || alarm !== 1'b1 || unlock !== 1'b0) begin
            errors++;
            $display("FAIL ajar_alarm: got state=%0d alarm=%b unlock=%b expected 3 1 0",
                     state, alarm, unlock);
        end
        alarm_clr = 1'b1;
        step();
        step();
        checks++;
        if (state !== 2'd3) begin
            errors++;
            $display("FAIL clr_door_open: got %0d expected 3", state);
        end
        door_closed = 1'b1;
        step();
        alarm_clr = 1'b0;
        checks++;
        if (state !== 2'd0 || alarm !== 1'b0 || entry_cnt !== 8'd3) begin
            errors++;
            $display("FAIL clr_ok: got state=%0d alarm=%b cnt=%0d expected 0 0 3",
                     state, alarm, entry_cnt);
        end
    endtask

    task automatic test_forced_entry();
        door_closed = 1'b0;
        open_req    = 1'b1;
        step();
        open_req = 1'b0;
        checks++;
        if (state !== 2'd3 || entry_cnt !== 8'd3) begin
            errors++;
            $display("FAIL forced: got state=%0d cnt=%0d expected 3 3",
                     state, entry_cnt);
        end
        door_closed = 1'b1;
        step();
        checks++;
        if (state !== 2'd3) begin
            errors++;
            $display("FAIL alarm_hold: got %0d expected 3", state);
        end
        alarm_clr = 1'b1;
        step();
        alarm_clr = 1'b0;
        checks++;
        if (state !== 2'd0) begin
            errors++;
            $display("FAIL forced_clr: got %0d expected 0", state);
        end
    endtask

    task automatic test_extend();
        open_req = 1'b1;
        step();
        open_req = 1'b0;
        step();
        step();
        open_req = 1'b1;
        step();
        open_req = 1'b0;
        // Window reloaded: 4 more unlocked cycles from the re-request edge.
        for (int i = 1; i < 4; i++) begin
            step();
            checks++;
            if (state !== 2'd1) begin
                errors++;
                $display("FAIL extend_%0d: got %0d expected 1", i, state);
            end
        end
        step();
        checks++;
        if (state !== 2'd0 || entry_cnt !== 8'd4) begin
            errors++;
            $display("FAIL extend_end: got state=%0d cnt=%0d expected 0 4",
                     state, entry_cnt);
        end
    endtask

    task automatic test_back_to_back();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int g = 1; g <= 256; g++) begin
            open_req = 1'b1;
            step();
            open_req = 1'b0;
            step();
            step();
            step();
            step();
            if (g == 255) begin
                checks++;
                if (entry_cnt !== 8'd255 || state !== 2'd0) begin
                    errors++;
                    $display("FAIL cnt_255: got cnt=%0d state=%0d expected 255 0",
                             entry_cnt, state);
                end
            end
        end
        checks++;
        if (entry_cnt !== 8'd0) begin
            errors++;
            $display("FAIL cnt_wrap: got %0d expected 0", entry_cnt);
        end
        open_req = 1'b1;
        step();
        open_req    = 1'b0;
        door_closed = 1'b0;
        step();
        checks++;
        if (state !== 2'd2 || entry_cnt !== 8'd1) begin
            errors++;
            $display("FAIL pre_rst_open: got state=%0d cnt=%0d expected 2 1",
                     state, entry_cnt);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++;
        if (state !== 2'd0 || unlock !== 1'b0 || entry_cnt !== 8'd0) begin
            errors++;
            $display("FAIL rst_in_open: got state=%0d unlock=%b cnt=%0d expected 0 0 0",
                     state, unlock, entry_cnt);
        end
        step();
        checks++;
        if (state !== 2'd3) begin
            errors++;
            $display("FAIL post_rst_forced: got %0d expected 3", state);
        end
        rst_n = 1'b0;
        step();
        rst_n       = 1'b1;
        door_closed = 1'b1;
        checks++;
        if (state !== 2'd0 || alarm !== 1'b0) begin
            errors++;
            $display("FAIL rst_in_alarm: got state=%0d alarm=%b expected 0 0",
                     state, alarm);
        end
    endtask

    initial begin
        test_reset();
        test_unlock_window();
        test_open_close();
        test_ajar_alarm();
        test_forced_entry();
        test_extend();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
